// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding selects over NSRC producer stages (youngest wins) plus a
// load-use hazard controller with a saturating stall-cycle counter.
module fwd_hazard_unit #(
    parameter  int REG_AW   = 5,
    parameter  int NSRC     = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int FW_W     = $clog2(NSRC + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_AW-1:0]      rs1_ex,
    input  logic [REG_AW-1:0]      rs2_ex,
    input  logic [NSRC*REG_AW-1:0] rd_src,
    input  logic [NSRC-1:0]        RegWrite_src,
    input  logic [REG_AW-1:0]      rs1_id,
    input  logic [REG_AW-1:0]      rs2_id,
    input  logic                   use_rs1_id,
    input  logic                   use_rs2_id,
    input  logic [REG_AW-1:0]      rd_ex,
    input  logic                   RegWrite_ex,
    input  logic                   MemRead_ex,
    input  logic                   mem_busy,
    input  logic                   flush,
    input  logic                   perf_clr,
    output logic [FW_W-1:0]        forwardA,
    output logic [FW_W-1:0]        forwardB,
    output logic                   stall_pc,
    output logic                   bubble_ex,
    output logic                   lu_busy,
    output logic [CNT_W-1:0]       stall_cycles
);

    localparam int CNT_CW = $clog2(LOAD_LAT + 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t              state, state_n;
    logic [CNT_CW-1:0]   cnt, cnt_n;
    logic                haz;
    logic                hit_a, hit_b;

    // Scan from the youngest slot; the first hit locks the select.
    always_comb begin
        forwardA = '0;
        forwardB = '0;
        hit_a    = 1'b0;
        hit_b    = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!hit_a && RegWrite_src[i] && rd_src[i*REG_AW +: REG_AW] != '0 &&
                rd_src[i*REG_AW +: REG_AW] == rs1_ex) begin
                forwardA = FW_W'(i + 1);
                hit_a    = 1'b1;
            end
            if (!hit_b && RegWrite_src[i] && rd_src[i*REG_AW +: REG_AW] != '0 &&
                rd_src[i*REG_AW +: REG_AW] == rs2_ex) begin
                forwardB = FW_W'(i + 1);
                hit_b    = 1'b1;
            end
        end
    end

    assign haz = MemRead_ex && RegWrite_ex && (rd_ex != '0) &&
                 ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (mem_busy) begin
            if (flush) begin
                state_n = RUN;
                cnt_n   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!flush && haz) begin
                        cnt_n   = CNT_CW'(LOAD_LAT - 1);
                        state_n = (LOAD_LAT > 1) ? LU_STALL : RUN;
                    end
                end
                LU_STALL: begin
                    if (flush) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - CNT_CW'(1);
                        if (cnt == CNT_CW'(1)) begin
                            state_n = RUN;
                        end
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    // Reset gates the stall outputs combinationally so a mid-stall reset
    // releases the pipeline in the same cycle.
    always_comb begin
        stall_pc  = 1'b0;
        bubble_ex = 1'b0;
        if (rst_n) begin
            if (mem_busy) begin
                stall_pc = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (!flush && haz) begin
                            stall_pc  = 1'b1;
                            bubble_ex = 1'b1;
                        end
                    end
                    LU_STALL: begin
                        if (!flush) begin
                            stall_pc  = 1'b1;
                            bubble_ex = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lu_busy = rst_n && (state == LU_STALL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (bubble_ex && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a 2-source/1-cycle/2-bit-counter instance
// and a 4-source/3-cycle instance driven from shared pipeline inputs.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_ex, rs2_ex, rs1_id, rs2_id, rd_ex;
    logic [9:0]  rd_src2;
    logic [1:0]  rw_src2;
    logic [19:0] rd_src4;
    logic [3:0]  rw_src4;
    logic        use_rs1_id, use_rs2_id, RegWrite_ex, MemRead_ex;
    logic        mem_busy, flush, perf_clr;

    logic [1:0]  fa2, fb2, sc2;
    logic        st2, bb2, lb2;
    logic [2:0]  fa4, fb4;
    logic        st4, bb4, lb4;
    logic [15:0] sc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(5), .NSRC(2), .LOAD_LAT(1), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_src(rd_src2), .RegWrite_src(rw_src2), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .mem_busy(mem_busy),
        .flush(flush), .perf_clr(perf_clr), .forwardA(fa2), .forwardB(fb2),
        .stall_pc(st2), .bubble_ex(bb2), .lu_busy(lb2), .stall_cycles(sc2)
    );

    fwd_hazard_unit #(.REG_AW(5), .NSRC(4), .LOAD_LAT(3), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_src(rd_src4), .RegWrite_src(rw_src4), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .rd_ex(rd_ex),
        .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex), .mem_busy(mem_busy),
        .flush(flush), .perf_clr(perf_clr), .forwardA(fa4), .forwardB(fb4),
        .stall_pc(st4), .bubble_ex(bb4), .lu_busy(lb4), .stall_cycles(sc4)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [9:0]  rd2;
        logic [1:0]  rw2;
        logic [19:0] rd4;
        logic [3:0]  rw4;
        logic        mr;
        logic [4:0]  rdx, r1id, r2id;
        logic        u1, u2;
        logic [1:0]  a2, b2;
        logic [2:0]  a4, b4;
        logic        st;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rs1_ex = '0; rs2_ex = '0; rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rd_src2 = '0; rw_src2 = '0; rd_src4 = '0; rw_src4 = '0;
        use_rs1_id = 1'b0; use_rs2_id = 1'b0; RegWrite_ex = 1'b0; MemRead_ex = 1'b0;
        mem_busy = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic set_load_hazard(input logic mr);
        RegWrite_ex = 1'b1;
        rd_ex       = 5'd7;
        rs2_id      = 5'd7;
        use_rs2_id  = 1'b1;
        use_rs1_id  = 1'b0;
        MemRead_ex  = mr;
    endtask

    // One bit per cycle (bit 0 = first cycle); checks the 4-source instance.
    task automatic run_seq(input string name, input int n,
                           input logic [7:0] mr_v, input logic [7:0] mb_v,
                           input logic [7:0] fl_v, input logic [7:0] es,
                           input logic [7:0] eb, input logic [7:0] ebusy,
                           input logic [15:0] exp_cnt);
        do_reset();
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            set_load_hazard(mr_v[c]);
            mem_busy = mb_v[c];
            flush    = fl_v[c];
            @(negedge clk);
            chk({name, "_stall"},  32'(st4), 32'(es[c]));
            chk({name, "_bubble"}, 32'(bb4), 32'(eb[c]));
            chk({name, "_busy"},   32'(lb4), 32'(ebusy[c]));
        end
        chk({name, "_count"}, 32'(sc4), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rs1    rs2    rd2 {s1,s0}      rw2    rd4 {s3,s2,s1,s0}            rw4      mr    rdx    r1id   r2id   u1    u2    a2    b2    a4    b4    st
        vt[0]  = '{5'd5, 5'd0, {5'd5, 5'd5}, 2'b11, {5'd5, 5'd5, 5'd5, 5'd5}, 4'b1111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd1, 2'd0, 3'd1, 3'd0, 1'b0};
        vt[1]  = '{5'd5, 5'd0, {5'd5, 5'd5}, 2'b10, {5'd5, 5'd5, 5'd5, 5'd5}, 4'b1110, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 2'd0, 3'd2, 3'd0, 1'b0};
        vt[2]  = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b11, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b1111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0};
        vt[3]  = '{5'd2, 5'd9, {5'd2, 5'd9}, 2'b11, {5'd9, 5'd9, 5'd2, 5'd1}, 4'b1111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd2, 3'd3, 1'b0};
        vt[4]  = '{5'd2, 5'd9, {5'd9, 5'd9}, 2'b00, {5'd3, 5'd3, 5'd3, 5'd3}, 4'b1111, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0};
        vt[5]  = '{5'd9, 5'd9, {5'd9, 5'd4}, 2'b11, {5'd9, 5'd9, 5'd0, 5'd0}, 4'b1011, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'd2, 2'd2, 3'd4, 3'd4, 1'b0};
        vt[6]  = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1};
        vt[7]  = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0};
        vt[8]  = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0};
        vt[9]  = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1};
        vt[10] = '{5'd0, 5'd0, {5'd0, 5'd0}, 2'b00, {5'd0, 5'd0, 5'd0, 5'd0}, 4'b0000, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0};

        rst_n = 1'b0;
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_cnt2", 32'(sc2), 32'd0);
        chk("rst_cnt4", 32'(sc4), 32'd0);
        chk("rst_stall4", 32'(st4), 32'd0);
        chk("rst_busy4", 32'(lb4), 32'd0);

        // Combinational forwarding and hazard detection; the 2-source
        // instance has a one-cycle load latency so it never leaves RUN.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            rs1_ex = vt[i].rs1;  rs2_ex = vt[i].rs2;
            rd_src2 = vt[i].rd2; rw_src2 = vt[i].rw2;
            rd_src4 = vt[i].rd4; rw_src4 = vt[i].rw4;
            MemRead_ex = vt[i].mr; RegWrite_ex = 1'b1; rd_ex = vt[i].rdx;
            rs1_id = vt[i].r1id; rs2_id = vt[i].r2id;
            use_rs1_id = vt[i].u1; use_rs2_id = vt[i].u2;
            @(negedge clk);
            chk($sformatf("v%0d_fA2", i), 32'(fa2), 32'(vt[i].a2));
            chk($sformatf("v%0d_fB2", i), 32'(fb2), 32'(vt[i].b2));
            chk($sformatf("v%0d_fA4", i), 32'(fa4), 32'(vt[i].a4));
            chk($sformatf("v%0d_fB4", i), 32'(fb4), 32'(vt[i].b4));
            chk($sformatf("v%0d_stall2", i), 32'(st2), 32'(vt[i].st));
        end

        // Single-cycle load-use on the LOAD_LAT=1 instance.
        do_reset();
        @(posedge clk); #1;
        set_load_hazard(1'b1);
        @(negedge clk);
        chk("ll1_stall", 32'(st2), 32'd1);
        chk("ll1_bubble", 32'(bb2), 32'd1);
        chk("ll1_busy", 32'(lb2), 32'd0);
        @(posedge clk); #1;
        MemRead_ex = 1'b0;
        @(negedge clk);
        chk("ll1_stall_end", 32'(st2), 32'd0);
        chk("ll1_busy_end", 32'(lb2), 32'd0);
        chk("ll1_count", 32'(sc2), 32'd1);

        run_seq("ll3",      4, 8'b0001,   8'b0000,   8'b000, 8'b0111,   8'b0111,   8'b0110,   16'd3);
        run_seq("ll3_mb",   6, 8'b000001, 8'b000110, 8'b0,   8'b011111, 8'b011001, 8'b011110, 16'd3);
        run_seq("ll3_fl",   3, 8'b001,    8'b000,    8'b010, 8'b001,    8'b001,    8'b010,    16'd1);
        run_seq("ll3_mbhz", 5, 8'b00011,  8'b00001,  8'b0,   8'b01111,  8'b01110,  8'b01100,  16'd3);

        // Saturation of the 2-bit counter, then clear racing a stall.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            set_load_hazard(1'b1);
        end
        @(posedge clk); #1;
        MemRead_ex = 1'b0;
        @(negedge clk);
        chk("sat_count", 32'(sc2), 32'd3);
        @(posedge clk); #1;
        MemRead_ex = 1'b1;
        perf_clr   = 1'b1;
        @(negedge clk);
        chk("clr_bubble", 32'(bb2), 32'd1);
        @(posedge clk); #1;
        MemRead_ex = 1'b0;
        perf_clr   = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(sc2), 32'd0);

        // Reset asserted in the middle of a multi-cycle stall.
        do_reset();
        @(posedge clk); #1;
        set_load_hazard(1'b1);
        @(negedge clk);
        chk("rmid_stall_pre", 32'(st4), 32'd1);
        @(posedge clk); #1;
        MemRead_ex = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk("rmid_stall", 32'(st4), 32'd0);
        chk("rmid_bubble", 32'(bb4), 32'd0);
        chk("rmid_busy", 32'(lb4), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rmid_state", 32'(lb4), 32'd0);
        chk("rmid_stall_post", 32'(st4), 32'd0);
        chk("rmid_count", 32'(sc4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised successor to the two-source forwarding unit. It generates ALU operand-forwarding selects over NSRC producer stages, with the youngest producer winning. It also adds a sequential load-use hazard controller that stalls PC/IF/ID and inserts EX bubbles for LOAD_LAT cycles, plus a saturating stall-cycle performance counter. It sits beside the ID/EX pipeline registers and drives the operand muxes and pipeline-register enables.

Parameters:
REG_AW, 5, register address width
NSRC, 2, number of forwarding source stages; index 0 is youngest (EX/MEM), NSRC-1 is oldest; range 1..7
LOAD_LAT, 1, load-use bubbles per hazard; minimum 1
CNT_W, 16, stall counter width
FW_W, $clog2(NSRC+1), derived width of the forward selects (localparam)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
rs1_ex  in  REG_AW  rs1 of the instruction in EX
rs2_ex  in  REG_AW  rs2 of the instruction in EX
rd_src  in  NSRC*REG_AW  destination of each source stage; slot i is bits [i*REG_AW +: REG_AW]
RegWrite_src  in  NSRC  write enable per source stage
rs1_id  in  REG_AW  rs1 of the instruction in ID
rs2_id  in  REG_AW  rs2 of the instruction in ID
use_rs1_id  in  1  ID instruction reads rs1
use_rs2_id  in  1  ID instruction reads rs2
rd_ex  in  REG_AW  destination of the instruction in EX
RegWrite_ex  in  1  EX instruction writes a register
MemRead_ex  in  1  EX instruction is a load
mem_busy  in  1  data memory not ready; freezes the controller
flush  in  1  branch redirect; squashes IF/ID
perf_clr  in  1  synchronous clear of stall_cycles
forwardA  out  FW_W  0 = register file; i+1 = source slot i
forwardB  out  FW_W  same encoding, for rs2
stall_pc  out  1  hold PC and IF/ID
bubble_ex  out  1  zero the ID/EX control signals
lu_busy  out  1  load-use FSM not in RUN
stall_cycles  out  CNT_W  count of load-use stall cycles

Behaviour:
- Forwarding is purely combinational with zero latency and is not affected by reset.
- forwardA = i+1 for the lowest i where RegWrite_src[i] && rd_src[i]!=0 && rd_src[i]==rs1_ex; 0 if no slot matches. forwardB uses rs2_ex with the same rule.
- With NSRC=2 the encoding is 01 for MEM and 10 for WB.
- haz = MemRead_ex && RegWrite_ex && rd_ex!=0 && ((use_rs1_id && rs1_id==rd_ex) || (use_rs2_id && rs2_id==rd_ex)).
- FSM states are RUN and LU_STALL; a down-counter cnt is $clog2(LOAD_LAT+1) bits wide.
- RUN:
  - if flush: no stall, stay in RUN.
  - else if haz: stall_pc=1, bubble_ex=1, cnt<=LOAD_LAT-1, next state = LU_STALL if LOAD_LAT>1, else RUN.
  - else: both stall outputs 0.
- LU_STALL: stall_pc=1, bubble_ex=1, cnt<=cnt-1. When cnt==1, next state is RUN.
- Total bubbles per hazard is exactly LOAD_LAT. haz is ignored while in LU_STALL.
- flush in LU_STALL: abort to RUN, cnt<=0, stall_pc=0 and bubble_ex=0 in that cycle.
- mem_busy:
  - state and cnt are frozen; stall_pc=1, bubble_ex=0.
  - stall_cycles does not increment.
  - flush still takes effect (FSM goes to RUN).
  - haz in RUN is not acted on until mem_busy deasserts.
- lu_busy = (state==LU_STALL).
- stall_cycles increments by 1 on each cycle with bubble_ex=1 and saturates at all-ones. perf_clr has priority over increment and clears it to 0.
- Reset (rst_n=0 at clk edge): state=RUN, cnt=0, stall_cycles=0.
- While rst_n=0: stall_pc=0, bubble_ex=0, lu_busy=0 (gated combinationally). Reset mid-stall aborts it.

Test Plan:
- NSRC=2, rs1_ex=5, rd_src slot0=5/RegWrite=1 and slot1=5/RegWrite=1 -> forwardA=1. Drop slot0 RegWrite -> forwardA=2. rd=0 in every slot -> forwardA=0.
- NSRC=4, rs2_ex=9 matching slots 2 and 3 only -> forwardB=3. Matching no slot -> forwardB=0.
- LOAD_LAT=1, MemRead_ex=1, rd_ex=7, rs2_id=7, use_rs2_id=1 -> stall_pc=bubble_ex=1 for exactly 1 cycle, stall_cycles=1, lu_busy never set.
- LOAD_LAT=3, same hazard -> 3 stall cycles, lu_busy high for cycles 2-3. mem_busy pulsed for 2 cycles in cycle 2 -> stall_pc high for 5 cycles total, bubble_ex high for 3 of them, stall_cycles=3.
- LOAD_LAT=3, flush asserted in the 2nd stall cycle -> stall_pc=0 that cycle, state RUN, stall_cycles=1.
- Hazard with use_rs1_id=0 and rs1_id==rd_ex -> no stall. CNT_W=2 after 5 stalls -> stall_cycles=3. perf_clr with a simultaneous stall -> 0. rst_n low mid-LU_STALL -> next cycle all outputs 0, state RUN.
